light_sequence_monitor: RTL
===========================

Name: light_sequence_monitor

Overview:
- Receiver-side checker for the 3-bit {R,Y,G} light bus driven by the traffic light controller.
- Samples the bus every clock and locks onto the RED->GREEN->YELLOW->RED sequence.
- Verifies one-hot encoding, phase order and per-phase dwell length.
- Reports the current phase, a sticky first-error code and a count of completed sequences; used on-chip as a safety watchdog and in benches as a checker.

Parameters:
- RED_CYCLES, 11, required consecutive samples of RED per phase
- GREEN_CYCLES, 9, required consecutive samples of GREEN per phase
- YELLOW_CYCLES, 4, required consecutive samples of YELLOW per phase
- CNT_W, 8, width of cycles_done

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset
- light_in  input  3  observed light bus {R,Y,G}; RED=100, YELLOW=010, GREEN=001
- clr  input  1  synchronous error clear / resync
- locked  output  1  1 while tracking a legal sequence
- phase  output  2  00 RED, 01 GREEN, 10 YELLOW, 11 not locked (SYNC or ERR)
- dwell  output  4  samples held in the current phase so far (1-based)
- err  output  1  sticky error flag
- err_code  output  2  first error: 00 none, 01 ILLEGAL, 10 ORDER, 11 DWELL
- cycles_done  output  CNT_W  completed RED-GREEN-YELLOW sequences, saturating

Behaviour:
- Reset (Already decided): one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: FSM=SYNC, prev sample=000, locked=0, phase=11, dwell=0, err=0, err_code=00, cycles_done=0.
- All outputs are registered. A sample taken at posedge N is reflected on the outputs after posedge N.
- FSM states: SYNC, RED, GREEN, YELLOW, ERR. In RED/GREEN/YELLOW, locked=1 and phase equals the held colour. In SYNC/ERR, phase=11 and locked=0.
- ILLEGAL check (all states except ERR):
  - any light_in not in {100,010,001} -> ERR, err=1, err_code=01.
  - Highest priority.
- SYNC:
  - prev sample is updated every cycle.
  - A GREEN sample with prev=RED -> GREEN state, dwell=1.
  - All other legal samples stay in SYNC with no dwell or order checks. This allows attach mid-sequence and covers the irregular first phase after controller reset.
- Tracked states, sample equal to the held colour:
  - if dwell == EXPECTED(held) -> ERR, err_code=11 (too long);
  - else dwell <= dwell+1.
- Tracked states, sample of a different legal colour:
  - if the colour is not the successor (RED->GREEN, GREEN->YELLOW, YELLOW->RED) -> ERR, err_code=10;
  - else if dwell != EXPECTED(held) -> ERR, err_code=11 (too short);
  - else enter the successor state with dwell=1.
- Priority when several faults coincide on one sample: ILLEGAL > ORDER > DWELL.
- cycles_done: +1 on each legal YELLOW->RED transition; holds at 2^CNT_W-1.
- ERR state:
  - stays in ERR until rst or clr;
  - light_in is ignored;
  - err_code holds the first error only;
  - dwell freezes at its value when the error was taken.
- clr (synchronous, 1 cycle):
  - FSM -> SYNC, err=0, err_code=00, dwell=0, prev=000.
  - cycles_done is retained.
  - clr wins over any check on the same sample.
  - clr in a tracked state also drops lock.
- dwell width is 4 bits; each parameter must be between 1 and 15.
- Reset mid-sequence behaves as power-up: the monitor must resync via SYNC.

Test Plan:
- Nominal: RED x20 (post-reset), then repeated GREEN x9, YELLOW x4, RED x11 for 3 sequences -> locked=1 from the first GREEN sample; err=0; cycles_done=3; phase tracks 01/10/00; dwell peaks at 9/4/11.
- Short dwell: lock, then GREEN x9, YELLOW x3, RED -> err=1, err_code=11 the cycle after the RED sample; phase=11; cycles_done=0.
- Long dwell: lock, then GREEN x10 -> err=1, err_code=11 the cycle after the 10th GREEN sample.
- Order and illegal:
  - lock, GREEN x9, then RED -> err_code=10;
  - after clr, resync, then inject 011 -> err_code=01;
  - injecting 011 and another fault together -> err_code=01.
- Sticky/clear: after an error, apply further faults -> err_code unchanged; pulse clr -> err=0, phase=11, cycles_done unchanged; a RED->GREEN pair relocks.
- Async reset mid-GREEN (not clock aligned) -> all outputs reach reset values immediately; cycles_done=0; relock requires a new RED->GREEN pair.
- Saturation: with CNT_W=2, run 5 legal sequences -> cycles_done=3.

Source files
------------

// File: rtl/light_sequence_monitor.sv
// light_sequence_monitor: receiver-side checker for the {R,Y,G} light bus.
// Locks onto RED->GREEN->YELLOW->RED and checks one-hot encoding, phase order
// and per-phase dwell length. Reports phase, a sticky first-error code and a
// saturating count of completed sequences. Each *_CYCLES value must be 1..15
// because dwell is a 4-bit counter.
module light_sequence_monitor #(
   parameter int RED_CYCLES    = 11,
   parameter int GREEN_CYCLES  = 9,
   parameter int YELLOW_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       light_in,
   input  logic             clr,
   output logic             locked,
   output logic [1:0]       phase,
   output logic [3:0]       dwell,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] cycles_done
);

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;

   localparam logic [3:0] RED_LEN    = 4'(RED_CYCLES);
   localparam logic [3:0] GREEN_LEN  = 4'(GREEN_CYCLES);
   localparam logic [3:0] YELLOW_LEN = 4'(YELLOW_CYCLES);

   localparam logic [1:0] E_NONE    = 2'b00;
   localparam logic [1:0] E_ILLEGAL = 2'b01;
   localparam logic [1:0] E_ORDER   = 2'b10;
   localparam logic [1:0] E_DWELL   = 2'b11;

   typedef enum logic [2:0] {
      S_SYNC,
      S_RED,
      S_GREEN,
      S_YELLOW,
      S_ERR
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       prev_q, prev_d;
   logic [3:0]       dwell_q, dwell_d;
   logic [1:0]       err_code_q, err_code_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;

   // Colour bookkeeping for the tracked state currently held.
   logic [2:0] held_code;
   logic [2:0] succ_code;
   state_t     succ_state;
   logic [3:0] exp_len;
   logic       illegal;

   // State register: every piece of monitor state lives here.
   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from the same pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_SYNC;
         prev_q     <= 3'b000;
         dwell_q    <= 4'd0;
         err_code_q <= E_NONE;
         cycles_q   <= '0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         dwell_q    <= dwell_d;
         err_code_q <= err_code_d;
         cycles_q   <= cycles_d;
      end
   end

   // Next-state logic: clr, then ILLEGAL > ORDER > DWELL checks on each sample.
   // NOTE: every variable gets a default at the top so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      dwell_d    = dwell_q;
      err_code_d = err_code_q;
      cycles_d   = cycles_q;

      held_code  = RED;
      succ_code  = GREEN;
      succ_state = S_GREEN;
      exp_len    = RED_LEN;
      case (state_q)
         S_GREEN: begin
            held_code  = GREEN;
            succ_code  = YELLOW;
            succ_state = S_YELLOW;
            exp_len    = GREEN_LEN;
         end
         S_YELLOW: begin
            held_code  = YELLOW;
            succ_code  = RED;
            succ_state = S_RED;
            exp_len    = YELLOW_LEN;
         end
         default: ;
      endcase

      illegal = !(light_in == RED || light_in == YELLOW || light_in == GREEN);

      if (clr) begin
         state_d    = S_SYNC;
         prev_d     = 3'b000;
         dwell_d    = 4'd0;
         err_code_d = E_NONE;
      end else if (state_q == S_ERR) begin
         // Frozen until clr or rst; the bus is ignored.
      end else begin
         prev_d = light_in;
         if (illegal) begin
            state_d    = S_ERR;
            err_code_d = E_ILLEGAL;
         end else if (state_q == S_SYNC) begin
            // Attach point: a RED->GREEN edge is the only trusted phase start.
            if (light_in == GREEN && prev_q == RED) begin
               state_d = S_GREEN;
               dwell_d = 4'd1;
            end
         end else if (light_in == held_code) begin
            if (dwell_q == exp_len) begin
               state_d    = S_ERR;
               err_code_d = E_DWELL;
            end else begin
               dwell_d = dwell_q + 4'd1;
            end
         end else if (light_in != succ_code) begin
            state_d    = S_ERR;
            err_code_d = E_ORDER;
         end else if (dwell_q != exp_len) begin
            state_d    = S_ERR;
            err_code_d = E_DWELL;
         end else begin
            state_d = succ_state;
            dwell_d = 4'd1;
            if (state_q == S_YELLOW && cycles_q != {CNT_W{1'b1}}) begin
               cycles_d = cycles_q + 1'b1;
            end
         end
      end
   end

   // Output decode: outputs depend only on registered state.
   always_comb begin
      locked      = 1'b0;
      phase       = 2'b11;
      case (state_q)
         S_RED:    begin locked = 1'b1; phase = 2'b00; end
         S_GREEN:  begin locked = 1'b1; phase = 2'b01; end
         S_YELLOW: begin locked = 1'b1; phase = 2'b10; end
         default:  ;
      endcase
      dwell       = dwell_q;
      err         = (state_q == S_ERR);
      err_code    = err_code_q;
      cycles_done = cycles_q;
   end

endmodule
